// File: rtl/kb_matrix_emu_if.sv
// Key-code handshake bundle between a code source and kb_matrix_emu.
//   KeyCode  : {row[2:0], col[1:0]}, col 3 is an invalid code
//   KeyValid : source has a code on KeyCode
//   KeyReady : emulator can accept a code this clock
// master = code source, slave = emulator.
interface kb_matrix_emu_if;
  logic [4:0] KeyCode;
  logic       KeyValid;
  logic       KeyReady;

  modport master (output KeyCode, output KeyValid, input  KeyReady);
  modport slave  (input  KeyCode, input  KeyValid, output KeyReady);
endinterface

// File: rtl/kb_matrix_emu.sv
// Keypad switch-matrix emulator. Stands in for a physical 8x3 keypad:
// accepts a key code, waits for the scanner's row select to wrap, then holds
// the key closed for HOLD_SCANS scan passes and released for GAP_SCANS passes
// before taking the next code.
//   Clk10M  : clock, rising edge
//   Clr     : synchronous active-low reset
//   De      : scanner row select (0..7), a pass ends when it wraps 7 -> 0
//   key     : code handshake (KeyCode/KeyValid in, KeyReady out)
//   Co      : active-low column lines, col 0 -> Co[1] .. col 2 -> Co[3]
//   Pressed : high while the key is being held
//   Err     : one-clock pulse after an invalid code (col 3) is accepted
module kb_matrix_emu #(
  parameter int unsigned HOLD_SCANS  = 4,
  parameter int unsigned GAP_SCANS   = 2,
  parameter int unsigned BOUNCE_CLKS = 0
) (
  input  logic           Clk10M,
  input  logic           Clr,
  input  logic [2:0]     De,
  kb_matrix_emu_if.slave key,
  output logic [1:3]     Co,
  output logic           Pressed,
  output logic           Err
);

  localparam logic [3:0] HOLD_N   = HOLD_SCANS[3:0];
  localparam logic [3:0] GAP_N    = GAP_SCANS[3:0];
  localparam logic [3:0] BOUNCE_N = BOUNCE_CLKS[3:0];

  typedef enum logic [1:0] {IDLE, ALIGN, PRESS, GAP} state_t;

  state_t     state, state_nxt;
  logic [4:0] code, code_nxt;
  logic [3:0] pass_cnt, pass_nxt;
  logic [3:0] bounce_cnt, bounce_nxt;
  logic       err_nxt;
  logic [2:0] DePrev;
  logic       wrap;
  logic       contact;

  assign wrap = (DePrev == 3'b111) && (De == 3'b000);

  always_comb begin
    state_nxt  = state;
    code_nxt   = code;
    pass_nxt   = pass_cnt;
    bounce_nxt = bounce_cnt;
    err_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (key.KeyValid) begin
          code_nxt = key.KeyCode;
          pass_nxt = '0;
          if (key.KeyCode[1:0] == 2'd3) begin
            err_nxt   = 1'b1;
            state_nxt = GAP;
          end else begin
            state_nxt = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (wrap) begin
          state_nxt  = PRESS;
          pass_nxt   = '0;
          bounce_nxt = '0;
        end
      end
      PRESS: begin
        if (bounce_cnt != BOUNCE_N) bounce_nxt = bounce_cnt + 4'd1;
        if (wrap) begin
          if (pass_cnt + 4'd1 == HOLD_N) begin
            state_nxt = GAP;
            pass_nxt  = '0;
          end else begin
            pass_nxt = pass_cnt + 4'd1;
          end
        end
      end
      GAP: begin
        if (wrap) begin
          if (pass_cnt + 4'd1 == GAP_N) begin
            state_nxt = IDLE;
            pass_nxt  = '0;
          end else begin
            pass_nxt = pass_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk10M) begin
    DePrev <= De;
    if (!Clr) begin
      state      <= IDLE;
      code       <= '0;
      pass_cnt   <= '0;
      bounce_cnt <= '0;
      Err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      pass_cnt   <= pass_nxt;
      bounce_cnt <= bounce_nxt;
      Err        <= err_nxt;
    end
  end

  // The bounce counter starts at 0 and saturates at BOUNCE_N, so "at or above
  // BOUNCE_N" reduces to equality; odd counts below it model an open contact.
  assign contact = (state == PRESS) &&
                   ((bounce_cnt == BOUNCE_N) || !bounce_cnt[0]);

  // Passive matrix: only the selected row can pull its column low.
  always_comb begin
    Co = '1;
    if (contact && (De == code[4:2])) begin
      unique case (code[1:0])
        2'd0:    Co[1] = 1'b0;
        2'd1:    Co[2] = 1'b0;
        2'd2:    Co[3] = 1'b0;
        default: Co    = '1;
      endcase
    end
  end

  assign Pressed      = (state == PRESS);
  assign key.KeyReady = (state == IDLE);

endmodule

// File: tb/tb_kb_matrix_emu.sv
module tb_kb_matrix_emu;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int BNC  = 3;

  logic       clk = 1'b0;
  logic       Clr;
  logic [2:0] de;
  logic [4:0] kc;
  logic       kv;
  logic [1:3] co_a, co_b;
  logic       pressed_a, pressed_b, err_a, err_b;

  always #50 clk = ~clk;

  kb_matrix_emu_if kif_a ();
  kb_matrix_emu_if kif_b ();
  assign kif_a.KeyCode  = kc;
  assign kif_a.KeyValid = kv;
  assign kif_b.KeyCode  = kc;
  assign kif_b.KeyValid = kv;

  kb_matrix_emu #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .BOUNCE_CLKS(0)) dut_a (
    .Clk10M(clk), .Clr(Clr), .De(de), .key(kif_a),
    .Co(co_a), .Pressed(pressed_a), .Err(err_a));

  kb_matrix_emu #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .BOUNCE_CLKS(BNC)) dut_b (
    .Clk10M(clk), .Clr(Clr), .De(de), .key(kif_b),
    .Co(co_b), .Pressed(pressed_b), .Err(err_b));

  // Reference model: an accepted code is described by how many scanner wraps
  // have completed since acceptance. Valid: pressed while 1..HOLD wraps have
  // completed, free again after 1+HOLD+GAP. Invalid: free after GAP wraps.
  int         cyc = 0, n_acc = 0, m_w = 0, m_entry = 0;
  bit         m_act = 0, m_valid = 0, m_err = 0, exp_p = 0;
  logic [4:0] m_code = '0;
  logic [2:0] m_deprev = '0;
  logic [4:0] src_q[$];
  int         de_left = 4;
  bit         de_rand = 0;
  int         checks = 0, errors = 0;
  logic [11:0] obs, expv;

  function automatic logic [1:3] model_co(input int b);
    logic [1:3] v;
    int d;
    v = '1;
    d = cyc - m_entry;
    if (exp_p && (d >= b || d % 2 == 0) && de == m_code[4:2])
      v[1 + int'(m_code[1:0])] = 1'b0;
    return v;
  endfunction

  task automatic push_code(input logic [4:0] c);
    if (src_q.size() == 0) begin
      kc = c;
      kv = 1'b1;
    end
    src_q.push_back(c);
  endtask

  // One rising edge: advance model, then step the scanner and code source.
  task automatic tick();
    bit wrap;
    @(posedge clk);
    wrap = (m_deprev == 3'd7) && (de == 3'd0);
    if (!Clr) begin
      m_act  = 0;
      m_err  = 0;
      m_code = '0;
    end else begin
      m_err = 0;
      if (!m_act) begin
        if (kv) begin
          m_act   = 1;
          m_code  = kc;
          m_valid = (kc[1:0] != 2'd3);
          m_w     = 0;
          m_err   = !m_valid;
          n_acc++;
          if (src_q.size() != 0) void'(src_q.pop_front());
        end
      end else if (wrap) begin
        m_w++;
        if (m_w == 1 && m_valid) m_entry = cyc + 1;
        if (m_w == (m_valid ? 1 + HOLD + GAP : GAP)) m_act = 0;
      end
    end
    m_deprev = de;
    cyc++;
    #1;
    if (de_left <= 1) begin
      de      = de + 3'd1;
      de_left = de_rand ? int'($urandom_range(2, 5)) : 4;
    end else begin
      de_left--;
    end
    kv = (src_q.size() != 0);
    if (kv) kc = src_q[0];
  endtask

  // Mid-cycle: sample DUT outputs and form model expectations.
  task automatic settle();
    @(negedge clk);
    exp_p = m_act && m_valid && m_w >= 1 && m_w <= HOLD;
    obs  = {co_a, co_b, kif_a.KeyReady, kif_b.KeyReady,
            pressed_a, pressed_b, err_a, err_b};
    expv = {model_co(0), model_co(BNC), !m_act, !m_act,
            exp_p, exp_p, m_err, m_err};
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    push_code(5'b01001);
    repeat (2) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      checks++;
      if ({co_a, kif_a.KeyReady, pressed_a, err_a} !== 6'b111100) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=111100", cyc,
                 {co_a, kif_a.KeyReady, pressed_a, err_a});
      end
    end
    src_q.delete();
    kv  = 1'b0;
    Clr = 1'b1;
    tick();
    settle();
    checks++;
    if (kif_a.KeyReady !== 1'b1 || pressed_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept ready=%b pressed=%b exp ready=1 pressed=0",
               kif_a.KeyReady, pressed_a);
    end
  endtask

  task automatic test_press();
    int n101 = 0;
    bit done = 0;
    push_code(5'b01001);
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL press cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (co_a == 3'b101) n101++;
      done = (src_q.size() == 0) && !m_act;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL press_timeout ready=%b exp=1", kif_a.KeyReady);
    end
    checks++;
    if (n101 != 16) begin
      errors++;
      $display("FAIL press_window clocks_low=%0d exp=16", n101);
    end
  endtask

  task automatic test_invalid();
    int n_err = 0, n_co = 0;
    bit done = 0;
    push_code(5'b00011);
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL invalid cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (err_a === 1'b1) n_err++;
      if (co_a !== 3'b111) n_co++;
      done = (src_q.size() == 0) && !m_act;
    end
    checks++;
    if (n_err != 1 || n_co != 0 || !done) begin
      errors++;
      $display("FAIL invalid_summary err_clks=%0d co_active=%0d done=%0b exp 1 0 1",
               n_err, n_co, done);
    end
  endtask

  task automatic test_back_to_back();
    int last7 = -1, first0 = -1;
    bit done = 0;
    push_code(5'b11100);
    push_code(5'b00001);
    for (int i = 0; i < 1000 && !done; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (co_a == 3'b011) last7 = cyc;
      if (co_a == 3'b101 && first0 < 0) first0 = cyc;
      done = (src_q.size() == 0) && !m_act;
    end
    checks++;
    if (!done || last7 < 0 || first0 <= last7) begin
      errors++;
      $display("FAIL b2b_order last_row7=%0d first_row0=%0d done=%0b exp first_row0>last_row7",
               last7, first0, done);
    end
  endtask

  task automatic test_reset_during_press();
    bit hit = 0, done = 0;
    push_code(5'b10110);
    for (int i = 0; i < 600 && !hit; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rstpress cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      hit = m_act && m_valid && m_w == 2 && de == 3'd5;
    end
    Clr = 1'b0;
    tick();
    Clr = 1'b1;
    settle();
    checks++;
    if (!hit || co_a !== 3'b111 || kif_a.KeyReady !== 1'b1 || pressed_a !== 1'b0) begin
      errors++;
      $display("FAIL rstpress_release hit=%0b co=%b ready=%b pressed=%b exp 1 111 1 0",
               hit, co_a, kif_a.KeyReady, pressed_a);
    end
    push_code(5'b00000);
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL rstpress_next cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      done = (src_q.size() == 0) && !m_act;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rstpress_next_timeout ready=%b exp=1", kif_a.KeyReady);
    end
  endtask

  task automatic test_bounce();
    logic [1:3] tbl [3];
    int n_b = 0;
    bit done = 0;
    tbl[0] = 3'b110;
    tbl[1] = 3'b111;
    tbl[2] = 3'b110;
    push_code(5'b00010);
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      settle();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      if (exp_p && cyc - m_entry < 3) begin
        n_b++;
        checks++;
        if (co_b !== tbl[cyc - m_entry] || co_a !== 3'b110) begin
          errors++;
          $display("FAIL bounce_seq step=%0d co_b=%b exp=%b co_a=%b exp=110",
                   cyc - m_entry, co_b, tbl[cyc - m_entry], co_a);
        end
      end
      done = (src_q.size() == 0) && !m_act;
    end
    checks++;
    if (n_b != 3 || !done) begin
      errors++;
      $display("FAIL bounce_steps seen=%0d done=%0b exp 3 1", n_b, done);
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [1:0] c;
    de_rand = 1;
    for (int it = 0; it < 20; it++) begin
      int n, rst_at;
      bit done = 0;
      n      = int'($urandom_range(1, 2));
      rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(5, 150)) : -1;
      for (int k = 0; k < n; k++) begin
        r = 3'($urandom_range(0, 7));
        c = 2'($urandom_range(0, 3));
        push_code({r, c});
      end
      for (int i = 0; i < 1000 && !done; i++) begin
        Clr = (i == rst_at) ? 1'b0 : 1'b1;
        tick();
        settle();
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, cyc, obs, expv);
        end
        done = (src_q.size() == 0) && !m_act && (i > rst_at);
      end
      Clr = 1'b1;
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL random_timeout it=%0d ready=%b exp=1", it, kif_a.KeyReady);
      end
    end
  endtask

  initial begin
    Clr = 1'b0;
    kv  = 1'b0;
    kc  = '0;
    de  = '0;
    test_reset();
    test_press();
    test_invalid();
    test_back_to_back();
    test_reset_during_press();
    test_bounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #6_000_000;
    $display("FAIL watchdog cyc=%0d exp=completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
